// File: rtl/aes_pkg.sv
// Shared AES SubBytes definitions: field constants, FSM state type and GF(2^8)/affine helpers.
// Used by the S-box lane and the iterative SubBytes engine.
package aes_pkg;

  localparam logic [7:0] GF_POLY      = 8'h1B;
  localparam logic [7:0] AFFINE_C     = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  // Shift-and-add multiply, reducing by x^8+x^4+x^3+x+1 whenever the top bit falls out.
  function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ s;
      s = s[7] ? ({s[6:0], 1'b0} ^ GF_POLY) : {s[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ AFFINE_C;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ INV_AFFINE_C;
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational AES S-box lane, forward or inverse, around a single shared field inverter.
// Zero latency; no handshake, the caller owns all flow control.
module sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] x,
  input  logic       inv,
  output logic [7:0] y
);

  // a^254 == a^-1 for nonzero a, and maps 0 to 0 as SubBytes requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul8(p, p);
      r = gf_mul8(r, p);
    end
    return r;
  endfunction

  logic [7:0] pre;
  logic [7:0] mid;

  assign pre = inv ? affine_inv(x) : x;
  assign mid = gf_inv(pre);
  assign y   = inv ? mid : affine_fwd(mid);

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative SubBytes over a 128-bit state, LANES bytes per beat; result valid BEATS edges after accept.
// Holds the result while out_ready is low and refuses new input until the result has been taken.
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int BEATS = 16 / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LSH   = $clog2(LANES);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [127:0]       work_q, work_d;
  logic               mode_q, mode_d;

  logic [3:0]         beat_base;
  logic [LANES*8-1:0] lane_x;
  logic [LANES*8-1:0] lane_y;

  // First byte index handled in the current beat.
  assign beat_base = 4'(cnt_q) << LSH;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [3:0] idx;
    assign idx = beat_base + 4'(g);
    assign lane_x[g*8 +: 8] = work_q[{idx, 3'b000} +: 8];

    sbox_lane u_lane (
      .x   (lane_x[g*8 +: 8]),
      .inv (mode_q),
      .y   (lane_y[g*8 +: 8])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          mode_d  = in_inv;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        for (int l = 0; l < LANES; l++) begin
          work_d[{beat_base + 4'(l), 3'b000} +: 8] = lane_y[l*8 +: 8];
        end
        if (cnt_q == CNT_W'(BEATS - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
    end
  end

  assign out_state = work_q;

endmodule
